// File: rtl/jump_resolve_unit.sv
// jump_resolve_unit
//   Pipelined jump resolver. Decides the next fetch address from the opcode
//   and ALU flags, and supports CALL/RET through a LIFO return-address stack.
//   The result sits in a one-entry output register behind a valid/ready
//   handshake, so the fetch stage can stall the block.
//
// Parameters
//   WORD_SIZE   width of instruction, addresses and stack entries
//   STACK_DEPTH return-address stack entries (>= 2)
//   FLAG_WIDTH  ALU flag vector width (>= 8)
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         input handshake (in_ready is combinational)
//   instruction                 opcode in the top 8 bits
//   program_counter_address     fall-through address, also the return address
//   peek_jump_address           jump/call target
//   flags                       ZERO=7, SIGN=6, CARRY=5, OVERFLOW=4
//   clear_errors                synchronous clear of the sticky error bits
//   out_valid / out_ready       output handshake
//   new_address, taken          resolved address, 1 if not the fall-through
//   stack_count                 current stack occupancy
//   stack_overflow/underflow    sticky CALL-when-full / RET-when-empty flags
//
// Optional feature (macro JUMP_RESOLVE_STATS_EN)
//   Adds saturating taken_count / not_taken_count outputs that count accepted
//   conditional jumps (0x15-0x24). clear_errors also zeroes them.

module jump_resolve_unit #(
    parameter int WORD_SIZE   = 16,
    parameter int STACK_DEPTH = 8,
    parameter int FLAG_WIDTH  = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WORD_SIZE-1:0]               instruction,
    input  logic [WORD_SIZE-1:0]               program_counter_address,
    input  logic [WORD_SIZE-1:0]               peek_jump_address,
    input  logic [FLAG_WIDTH-1:0]              flags,
    input  logic                               clear_errors,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WORD_SIZE-1:0]               new_address,
    output logic                               taken,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
    output logic                               stack_overflow,
    output logic                               stack_underflow
`ifdef JUMP_RESOLVE_STATS_EN
    ,
    output logic [WORD_SIZE-1:0]               taken_count,
    output logic [WORD_SIZE-1:0]               not_taken_count
`endif
);

    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [7:0] OP_JMP  = 8'h14;
    localparam logic [7:0] OP_JE   = 8'h15;
    localparam logic [7:0] OP_JNE  = 8'h16;
    localparam logic [7:0] OP_JC   = 8'h17;
    localparam logic [7:0] OP_JNC  = 8'h18;
    localparam logic [7:0] OP_JS   = 8'h19;
    localparam logic [7:0] OP_JNS  = 8'h1A;
    localparam logic [7:0] OP_JO   = 8'h1B;
    localparam logic [7:0] OP_JNO  = 8'h1C;
    localparam logic [7:0] OP_JA   = 8'h1D;
    localparam logic [7:0] OP_JAE  = 8'h1E;
    localparam logic [7:0] OP_JB   = 8'h1F;
    localparam logic [7:0] OP_JBE  = 8'h20;
    localparam logic [7:0] OP_JG   = 8'h21;
    localparam logic [7:0] OP_JGE  = 8'h22;
    localparam logic [7:0] OP_JL   = 8'h23;
    localparam logic [7:0] OP_JLE  = 8'h24;
    localparam logic [7:0] OP_CALL = 8'h25;
    localparam logic [7:0] OP_RET  = 8'h26;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                 r_state;
    logic [WORD_SIZE-1:0]   r_new_address;
    logic                   r_taken;
    logic [CW-1:0]          r_count;
    logic                   r_overflow;
    logic                   r_underflow;
    logic [WORD_SIZE-1:0]   r_stack [STACK_DEPTH];

    logic [7:0]             w_op;
    logic                   w_z, w_s, w_c, w_o;
    logic                   w_cond;
    logic                   w_is_cond;
    logic                   w_is_call;
    logic                   w_is_ret;
    logic                   w_accept;
    logic                   w_stack_full;
    logic                   w_stack_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_take;
    logic [AW-1:0]          w_top_idx;
    logic [AW-1:0]          w_push_idx;
    logic [WORD_SIZE-1:0]   w_next_address;
    logic                   w_unused_bits;

    // Only the opcode byte and the four named flags are decoded.
    assign w_unused_bits = ^{instruction, flags};

    assign w_op = instruction[WORD_SIZE-1 -: 8];
    assign w_z  = flags[7];
    assign w_s  = flags[6];
    assign w_c  = flags[5];
    assign w_o  = flags[4];

    assign out_valid = (r_state == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;

    always_comb begin
        w_cond    = 1'b0;
        w_is_cond = 1'b1;
        w_is_call = 1'b0;
        w_is_ret  = 1'b0;
        case (w_op)
            OP_JMP:  begin w_cond = 1'b1;                      w_is_cond = 1'b0; end
            OP_JE:   w_cond = w_z;
            OP_JNE:  w_cond = !w_z;
            OP_JC:   w_cond = w_c;
            OP_JNC:  w_cond = !w_c;
            OP_JS:   w_cond = w_s;
            OP_JNS:  w_cond = !w_s;
            OP_JO:   w_cond = w_o;
            OP_JNO:  w_cond = !w_o;
            OP_JA:   w_cond = !w_c && !w_z;
            OP_JAE:  w_cond = !w_c;
            OP_JB:   w_cond = w_c;
            OP_JBE:  w_cond = w_c || w_z;
            OP_JG:   w_cond = !(w_s ^ w_o) && !w_z;
            OP_JGE:  w_cond = !(w_s ^ w_o);
            OP_JL:   w_cond = w_s ^ w_o;
            OP_JLE:  w_cond = (w_s ^ w_o) || w_z;
            OP_CALL: begin w_is_call = 1'b1; w_is_cond = 1'b0; end
            OP_RET:  begin w_is_ret  = 1'b1; w_is_cond = 1'b0; end
            default: w_is_cond = 1'b0;
        endcase
    end

    assign w_stack_full  = (r_count == CW'(STACK_DEPTH));
    assign w_stack_empty = (r_count == '0);
    assign w_push        = w_accept && w_is_call && !w_stack_full;
    assign w_pop         = w_accept && w_is_ret && !w_stack_empty;
    assign w_top_idx     = AW'(r_count - CW'(1));
    assign w_push_idx    = AW'(r_count);

    // A CALL with a full stack or a RET with an empty one degrades to a
    // fall-through so fetch keeps making forward progress.
    assign w_take = w_cond
                 || (w_is_call && !w_stack_full)
                 || (w_is_ret && !w_stack_empty);

    always_comb begin
        w_next_address = program_counter_address;
        if (w_take) begin
            w_next_address = w_is_ret ? r_stack[w_top_idx] : peek_jump_address;
        end
    end

    // Stack storage carries no reset: occupancy is tracked by r_count, so
    // stale entries are never observable.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= program_counter_address;
        end
    end

    // Output register state machine plus stack pointer and sticky errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_EMPTY;
            r_new_address <= '0;
            r_taken       <= 1'b0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (!w_accept && out_ready) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase

            if (w_accept) begin
                r_new_address <= w_next_address;
                r_taken       <= w_take;
            end

            if (w_push) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop) begin
                r_count <= r_count - CW'(1);
            end

            // A new error event wins over a coincident clear.
            r_overflow  <= (r_overflow && !clear_errors)
                        || (w_accept && w_is_call && w_stack_full);
            r_underflow <= (r_underflow && !clear_errors)
                        || (w_accept && w_is_ret && w_stack_empty);
        end
    end

    assign new_address     = r_new_address;
    assign taken           = r_taken;
    assign stack_count     = r_count;
    assign stack_overflow  = r_overflow;
    assign stack_underflow = r_underflow;

`ifdef JUMP_RESOLVE_STATS_EN
    logic [WORD_SIZE-1:0] r_taken_count;
    logic [WORD_SIZE-1:0] r_not_taken_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taken_count     <= '0;
            r_not_taken_count <= '0;
        end else if (clear_errors) begin
            r_taken_count     <= '0;
            r_not_taken_count <= '0;
        end else if (w_accept && w_is_cond) begin
            if (w_cond) begin
                if (r_taken_count != '1) begin
                    r_taken_count <= r_taken_count + WORD_SIZE'(1);
                end
            end else begin
                if (r_not_taken_count != '1) begin
                    r_not_taken_count <= r_not_taken_count + WORD_SIZE'(1);
                end
            end
        end
    end

    assign taken_count     = r_taken_count;
    assign not_taken_count = r_not_taken_count;
`endif

endmodule

// File: tb/tb_jump_resolve_unit.sv
module tb_jump_resolve_unit;

    localparam int W  = 16;
    localparam int SD = 8;
    localparam int FW = 8;
    localparam int CW = $clog2(SD + 1);

    localparam logic [7:0] OP_JMP  = 8'h14;
    localparam logic [7:0] OP_CALL = 8'h25;
    localparam logic [7:0] OP_RET  = 8'h26;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  instruction = '0;
    logic [W-1:0]  program_counter_address = '0;
    logic [W-1:0]  peek_jump_address = '0;
    logic [FW-1:0] flags = '0;
    logic          clear_errors = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  new_address;
    logic          taken;
    logic [CW-1:0] stack_count;
    logic          stack_overflow;
    logic          stack_underflow;

    jump_resolve_unit #(
        .WORD_SIZE   (W),
        .STACK_DEPTH (SD),
        .FLAG_WIDTH  (FW)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .instruction             (instruction),
        .program_counter_address (program_counter_address),
        .peek_jump_address       (peek_jump_address),
        .flags                   (flags),
        .clear_errors            (clear_errors),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .new_address             (new_address),
        .taken                   (taken),
        .stack_count             (stack_count),
        .stack_overflow          (stack_overflow),
        .stack_underflow         (stack_underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  fl;
        logic [15:0] pc;
        logic [15:0] peek;
        logic [15:0] exp_addr;
        logic        exp_taken;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [7:0] fl,
                         input logic [15:0] pc, input logic [15:0] peek);
        in_valid                = 1'b1;
        instruction             = {op, 8'h5A};
        flags                   = fl;
        program_counter_address = pc;
        peek_jump_address       = peek;
    endtask

    // One accepted instruction with out_ready=1; returns at the negedge
    // after the accepting edge, where the result must already be visible.
    task automatic send(input logic [7:0] op, input logic [7:0] fl,
                        input logic [15:0] pc, input logic [15:0] peek);
        @(negedge clk);
        out_ready = 1'b1;
        drive(op, fl, pc, peek);
        @(negedge clk);
        in_valid = 1'b0;
        $display("txn op=%02h flags=%02h pc=%04h peek=%04h -> addr=%04h taken=%0b count=%0d ovf=%0b unf=%0b",
                 op, fl, pc, peek, new_address, taken, stack_count, stack_overflow, stack_underflow);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{8'h15, 8'h80, 16'h0102, 16'h0400, 16'h0400, 1'b1}; // JE Z
        vecs[1]  = '{8'h15, 8'h00, 16'h0102, 16'h0400, 16'h0102, 1'b0}; // JE !Z
        vecs[2]  = '{8'h16, 8'h00, 16'h0102, 16'h0400, 16'h0400, 1'b1}; // JNE
        vecs[3]  = '{8'h17, 8'h20, 16'h0102, 16'h0400, 16'h0400, 1'b1}; // JC
        vecs[4]  = '{8'h18, 8'h20, 16'h0102, 16'h0400, 16'h0102, 1'b0}; // JNC
        vecs[5]  = '{8'h19, 8'h40, 16'h0102, 16'h0400, 16'h0400, 1'b1}; // JS
        vecs[6]  = '{8'h1A, 8'h40, 16'h0102, 16'h0400, 16'h0102, 1'b0}; // JNS
        vecs[7]  = '{8'h1B, 8'h10, 16'h0102, 16'h0400, 16'h0400, 1'b1}; // JO
        vecs[8]  = '{8'h1C, 8'h00, 16'h0102, 16'h0400, 16'h0400, 1'b1}; // JNO
        vecs[9]  = '{8'h1D, 8'hA0, 16'h0102, 16'h0400, 16'h0102, 1'b0}; // JA Z,C
        vecs[10] = '{8'h1D, 8'h00, 16'h0102, 16'h0400, 16'h0400, 1'b1}; // JA
        vecs[11] = '{8'h1E, 8'h20, 16'h0102, 16'h0400, 16'h0102, 1'b0}; // JAE C
        vecs[12] = '{8'h1F, 8'h20, 16'h0102, 16'h0400, 16'h0400, 1'b1}; // JB C
        vecs[13] = '{8'h20, 8'h80, 16'h0102, 16'h0400, 16'h0400, 1'b1}; // JBE Z
        vecs[14] = '{8'h20, 8'h00, 16'h0102, 16'h0400, 16'h0102, 1'b0}; // JBE
        vecs[15] = '{8'h21, 8'h50, 16'h0102, 16'h0400, 16'h0400, 1'b1}; // JG S,O
        vecs[16] = '{8'h21, 8'h40, 16'h0102, 16'h0400, 16'h0102, 1'b0}; // JG S
        vecs[17] = '{8'h22, 8'h10, 16'h0102, 16'h0400, 16'h0102, 1'b0}; // JGE O
        vecs[18] = '{8'h23, 8'h10, 16'h0102, 16'h0400, 16'h0400, 1'b1}; // JL O
        vecs[19] = '{8'h24, 8'h80, 16'h0102, 16'h0400, 16'h0400, 1'b1}; // JLE Z
        vecs[20] = '{8'h24, 8'h50, 16'h0102, 16'h0400, 16'h0102, 1'b0}; // JLE S,O
        vecs[21] = '{8'h14, 8'h00, 16'h0102, 16'h0400, 16'h0400, 1'b1}; // JMP
        vecs[22] = '{8'h00, 8'hF0, 16'h0102, 16'h0400, 16'h0102, 1'b0}; // unknown
        vecs[23] = '{8'h27, 8'hF0, 16'h0102, 16'h0400, 16'h0102, 1'b0}; // unknown

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_new_address", 32'(new_address), 32'd0);
        chk("rst_taken", 32'(taken), 32'd0);
        chk("rst_stack_count", 32'(stack_count), 32'd0);
        chk("rst_overflow", 32'(stack_overflow), 32'd0);
        chk("rst_underflow", 32'(stack_underflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Table of condition decodes
        for (int i = 0; i < NV; i++) begin
            send(vecs[i].op, vecs[i].fl, vecs[i].pc, vecs[i].peek);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_addr", i), 32'(new_address), 32'(vecs[i].exp_addr));
            chk($sformatf("vec%0d_taken", i), 32'(taken), 32'(vecs[i].exp_taken));
            chk($sformatf("vec%0d_count", i), 32'(stack_count), 32'd0);
        end

        // CALL then RET
        send(OP_CALL, 8'h00, 16'h0010, 16'h0200);
        chk("call_addr", 32'(new_address), 32'h0200);
        chk("call_taken", 32'(taken), 32'd1);
        chk("call_count", 32'(stack_count), 32'd1);
        send(OP_RET, 8'h00, 16'h0033, 16'h0777);
        chk("ret_addr", 32'(new_address), 32'h0010);
        chk("ret_taken", 32'(taken), 32'd1);
        chk("ret_count", 32'(stack_count), 32'd0);

        // Fill the stack, then one CALL too many
        for (int i = 0; i < SD; i++) begin
            send(OP_CALL, 8'h00, 16'h0100 + 16'(i), 16'h0800 + 16'(i));
            chk($sformatf("fill%0d_addr", i), 32'(new_address), 32'h0800 + 32'(i));
            chk($sformatf("fill%0d_count", i), 32'(stack_count), 32'(i + 1));
            chk($sformatf("fill%0d_ovf", i), 32'(stack_overflow), 32'd0);
        end
        send(OP_CALL, 8'h00, 16'h0108, 16'h0808);
        chk("ovf_addr", 32'(new_address), 32'h0108);
        chk("ovf_taken", 32'(taken), 32'd0);
        chk("ovf_flag", 32'(stack_overflow), 32'd1);
        chk("ovf_count", 32'(stack_count), 32'd8);
        @(negedge clk);
        clear_errors = 1'b1;
        @(negedge clk);
        clear_errors = 1'b0;
        chk("ovf_cleared", 32'(stack_overflow), 32'd0);
        chk("ovf_clear_count", 32'(stack_count), 32'd8);

        // Drain in LIFO order
        for (int i = SD - 1; i >= 0; i--) begin
            send(OP_RET, 8'h00, 16'h0F00, 16'h0EEE);
            chk($sformatf("pop%0d_addr", i), 32'(new_address), 32'h0100 + 32'(i));
            chk($sformatf("pop%0d_taken", i), 32'(taken), 32'd1);
            chk($sformatf("pop%0d_count", i), 32'(stack_count), 32'(i));
        end

        // RET on empty stack, coinciding with clear_errors: error wins
        clear_errors = 1'b1;
        send(OP_RET, 8'h00, 16'h0F10, 16'h0EEE);
        clear_errors = 1'b0;
        chk("unf_addr", 32'(new_address), 32'h0F10);
        chk("unf_taken", 32'(taken), 32'd0);
        chk("unf_flag", 32'(stack_underflow), 32'd1);
        chk("unf_count", 32'(stack_count), 32'd0);

        // Stall: result held while out_ready=0, then back-to-back
        @(negedge clk);
        out_ready = 1'b0;
        drive(OP_JMP, 8'h00, 16'h0111, 16'h0AAA);
        @(negedge clk);
        chk("stall_first_valid", 32'(out_valid), 32'd1);
        chk("stall_first_addr", 32'(new_address), 32'h0AAA);
        drive(OP_CALL, 8'h00, 16'h0333, 16'h0BBB);
        #1;
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_in_ready", i), 32'(in_ready), 32'd0);
            chk($sformatf("stall%0d_addr", i), 32'(new_address), 32'h0AAA);
            chk($sformatf("stall%0d_taken", i), 32'(taken), 32'd1);
            chk($sformatf("stall%0d_count", i), 32'(stack_count), 32'd0);
            chk($sformatf("stall%0d_valid", i), 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        $display("txn stall-release call -> addr=%04h taken=%0b count=%0d", new_address, taken, stack_count);
        chk("b2b_call_addr", 32'(new_address), 32'h0BBB);
        chk("b2b_call_count", 32'(stack_count), 32'd1);
        drive(OP_RET, 8'h00, 16'h0444, 16'h0CCC);
        @(negedge clk);
        $display("txn back-to-back ret -> addr=%04h taken=%0b count=%0d", new_address, taken, stack_count);
        chk("b2b_ret_addr", 32'(new_address), 32'h0333);
        chk("b2b_ret_taken", 32'(taken), 32'd1);
        chk("b2b_ret_count", 32'(stack_count), 32'd0);
        chk("b2b_ret_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-stream
        send(OP_CALL, 8'h00, 16'h0A00, 16'h0B00);
        send(OP_CALL, 8'h00, 16'h0A01, 16'h0B01);
        send(OP_CALL, 8'h00, 16'h0A02, 16'h0B02);
        chk("pre_rst_count", 32'(stack_count), 32'd3);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("txn async reset -> valid=%0b addr=%04h count=%0d", out_valid, new_address, stack_count);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_addr", 32'(new_address), 32'd0);
        chk("arst_taken", 32'(taken), 32'd0);
        chk("arst_count", 32'(stack_count), 32'd0);
        chk("arst_underflow", 32'(stack_underflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(OP_RET, 8'h00, 16'h0C00, 16'h0D00);
        chk("post_rst_ret_addr", 32'(new_address), 32'h0C00);
        chk("post_rst_ret_taken", 32'(taken), 32'd0);
        chk("post_rst_unf", 32'(stack_underflow), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
